mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single-port 32-entry register-style memory (5-bit address, combinational read, write on rising edge when `we & cs`). It sits between two masters, for example instruction fetch and load/store, and the memory instance. It grants at most one access per cycle with round-robin fairness and returns read data one cycle after the grant. A bounded lock lets one requester perform an atomic read-modify-write sequence.

## Interface
- `WIDTH`, default 32: data width. Must match the memory's `WIDTH`.
- `LOCK_MAX`, default 4: maximum number of cycles spent in the LOCKED state per lock. Legal range is 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  [1:0]  access request per requester.
- `req_ready`  out  [1:0]  grant; the access completes at the edge where `req_valid[i] & req_ready[i]`.
- `req_we`  in  [1:0]  1 = write, 0 = read.
- `req_lock`  in  [1:0]  request or extend the lock with this access.
- `req_addr`  in  [1:0][4:0]  word address per requester.
- `req_wd`  in  [1:0][WIDTH-1:0]  write data per requester.
- `rsp_valid`  out  [1:0]  one-cycle response pulse per requester.
- `rsp_rd`  out  [WIDTH-1:0]  read data, shared by both requesters; qualified by `rsp_valid`.
- `mem_cs`, `mem_we`  out  1  memory chip select and write enable.
- `mem_addr`  out  5  memory address.
- `mem_wd`  out  WIDTH  memory write data.
- `mem_rd`  in  WIDTH  memory read data (combinational from `mem_addr`).

## Operation
- **Registered state:**
  - `state` ∈ {ARB, LOCKED}
  - `owner` (1 bit)
  - `last_grant` (1 bit)
  - `lock_cnt` (4 bits)
  - `rsp_valid`
  - `rsp_rd`
- **ARB state:**
  - If exactly one `req_valid` bit is set, grant that requester.
  - If both are set, grant `~last_grant`.
  - If neither is set, grant nothing.
- **LOCKED state:**
  - Only `owner` is eligible; the other requester's `req_ready` stays 0.
  - If the owner is idle, there is no access that cycle.
- **Grant `g` (combinational):**
  - `req_ready[g]=1`, `mem_cs=1`, `mem_we=req_we[g]`, `mem_addr=req_addr[g]`, `mem_wd=req_wd[g]`.
  - With no grant: `mem_cs=0`, `mem_we=0`, `mem_addr=0`, `mem_wd=0`, `req_ready=0`.
- **On the granted edge:**
  - `last_grant<=g`
  - `rsp_valid<=onehot(g)`
  - `rsp_rd<=` `mem_rd` for a read, 0 for a write. A write response is an acknowledge only.
- **Without a grant:** `rsp_valid<=0` and `rsp_rd` holds its value.
- **ARB → LOCKED:** on a granted access with `req_lock[g]=1`. Sets `owner<=g` and `lock_cnt<=0`.
- **While in LOCKED:** `lock_cnt` increments every cycle, whether or not the owner accesses.
- **LOCKED → ARB (voluntary):** on an owner access with `req_lock=0`. That access is still performed.
- **LOCKED → ARB (forced):** at the end of the cycle in which `lock_cnt==LOCK_MAX-1`, regardless of `req_lock`.
  - An access made in that cycle is still performed.
  - `last_grant=owner`, so the other requester wins next if it is valid.
- **Non-owner `req_lock`** is ignored while in LOCKED.
- **Write/read ordering:** a write at edge N is visible to a read granted at cycle N+1. There is no bypass.

## Timing
- **Grant latency:** 0 cycles. `req_ready` is combinational from `req_valid`, `req_lock` and the current state.
- **Response latency:** `rsp_valid[g]` is high exactly one cycle after the grant cycle, for one cycle.
- **Throughput:** one access per cycle. With both requesters continuously valid and no lock, grants alternate every cycle.
- **Lock bound:**
  - Maximum consecutive owner grants = 1 + `LOCK_MAX`.
  - Maximum wait for the non-owner = 1 + `LOCK_MAX` cycles.
- **Reset values** (applied asynchronously while `rst=1`):
  - `state=ARB`, `owner=0`, `last_grant=1` (requester 0 wins the first tie), `lock_cnt=0`.
  - `rsp_valid=0`, `rsp_rd=0`.
  - `req_ready=0` and `mem_cs=0` while `rst` is high.
- **Reset mid-operation:** an in-flight response is dropped, and the lock is released immediately.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `rsp_valid=0`, `rsp_rd=0`, `req_ready=0`, `mem_cs=0` immediately. After release, both requesters valid → requester 0 is granted first.
- **Single access:**
  - Requester 0 writes 0xDEADBEEF to addr 3 → `mem_cs=1`, `mem_we=1`; next cycle `rsp_valid=2'b01`, `rsp_rd=0`.
  - Requester 0 then reads addr 3 → next cycle `rsp_rd=0xDEADBEEF`.
- **Round-robin:** both requesters continuously valid with reads to addr 1 / addr 2 → grants alternate 0,1,0,1. Each `rsp_valid` pulse lags its grant by 1 cycle.
- **Atomic RMW:** requester 0 reads addr 5 (`lock=1`), then writes addr 5 with `lock=0`; requester 1 is valid throughout.
  - Requester 1 sees `req_ready=0` for 2 cycles, then is granted.
  - Requester 1's read of addr 5 returns the written value.
- **Lock timeout** (`LOCK_MAX=4`): requester 0 is valid with `lock=1` forever and requester 1 is valid → requester 0 is granted for 5 consecutive cycles, then requester 1 for 1 cycle.
- **Idle owner:** requester 0 locks, then drops `req_valid` → no grants for 4 cycles while requester 1 waits, then requester 1 is granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port 32-entry memory, with a
// bounded lock so one requester can complete an atomic read-modify-write.
module mem_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_lock,
  input  logic [1:0][4:0]       req_addr,
  input  logic [1:0][WIDTH-1:0] req_wd,
  output logic [1:0]            rsp_valid,
  output logic [WIDTH-1:0]      rsp_rd,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [4:0]            mem_addr,
  output logic [WIDTH-1:0]      mem_wd,
  input  logic [WIDTH-1:0]      mem_rd
);

  typedef enum logic {StArb, StLocked} state_e;

  localparam logic [3:0] LockLast = 4'(LOCK_MAX - 1);

  state_e           r_state, w_state_d;
  logic             r_owner, w_owner_d;
  logic             r_last_grant, w_last_grant_d;
  logic [3:0]       r_lock_cnt, w_lock_cnt_d;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_rd;

  logic w_grant;
  logic w_g;

  // Grant selection; suppressed while reset is held.
  always_comb begin
    w_grant = 1'b0;
    w_g     = 1'b0;
    if (!rst) begin
      unique case (r_state)
        StArb: begin
          unique case (req_valid)
            2'b01:   begin w_grant = 1'b1; w_g = 1'b0;          end
            2'b10:   begin w_grant = 1'b1; w_g = 1'b1;          end
            2'b11:   begin w_grant = 1'b1; w_g = ~r_last_grant; end
            default: ;
          endcase
        end
        StLocked: begin
          w_grant = req_valid[r_owner];
          w_g     = r_owner;
        end
      endcase
    end
  end

  always_comb begin
    req_ready = w_grant ? (2'b01 << w_g) : 2'b00;
    mem_cs    = w_grant;
    mem_we    = w_grant & req_we[w_g];
    mem_addr  = w_grant ? req_addr[w_g] : 5'd0;
    mem_wd    = w_grant ? req_wd[w_g] : '0;
  end

  always_comb begin
    w_state_d      = r_state;
    w_owner_d      = r_owner;
    w_last_grant_d = r_last_grant;
    w_lock_cnt_d   = r_lock_cnt;
    if (w_grant) w_last_grant_d = w_g;
    unique case (r_state)
      StArb: begin
        if (w_grant && req_lock[w_g]) begin
          w_state_d    = StLocked;
          w_owner_d    = w_g;
          w_lock_cnt_d = 4'd0;
        end
      end
      StLocked: begin
        w_lock_cnt_d = r_lock_cnt + 4'd1;
        if (r_lock_cnt == LockLast) begin
          // Forced release: the other requester wins the next tie.
          w_state_d      = StArb;
          w_last_grant_d = r_owner;
        end else if (w_grant && !req_lock[r_owner]) begin
          w_state_d = StArb;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StArb;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_lock_cnt   <= 4'd0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rd     <= '0;
    end else begin
      r_state      <= w_state_d;
      r_owner      <= w_owner_d;
      r_last_grant <= w_last_grant_d;
      r_lock_cnt   <= w_lock_cnt_d;
      if (w_grant) begin
        r_rsp_valid <= 2'b01 << w_g;
        r_rsp_rd    <= req_we[w_g] ? '0 : mem_rd;
      end else begin
        r_rsp_valid <= 2'b00;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rd    = r_rsp_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of per-cycle requests with expected grants,
// a shadow memory predicting responses into a scoreboard queue, and reset sequences.
module tb_mem_arbiter;

  localparam int unsigned WIDTH = 32;

  logic                  clk;
  logic                  rst;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_we;
  logic [1:0]            req_lock;
  logic [1:0][4:0]       req_addr;
  logic [1:0][WIDTH-1:0] req_wd;
  logic [1:0]            rsp_valid;
  logic [WIDTH-1:0]      rsp_rd;
  logic                  mem_cs;
  logic                  mem_we;
  logic [4:0]            mem_addr;
  logic [WIDTH-1:0]      mem_wd;
  logic [WIDTH-1:0]      mem_rd;

  mem_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wd    (req_wd),
    .rsp_valid (rsp_valid),
    .rsp_rd    (rsp_rd),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory instance the arbiter drives.
  logic [WIDTH-1:0] mem [32];
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr] <= mem_wd;

  logic [WIDTH-1:0] shadow [32];

  function automatic logic [WIDTH-1:0] init_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'd3;
  endfunction

  typedef struct {
    logic [1:0]       valid;
    logic [1:0]       we;
    logic [1:0]       lock;
    logic [4:0]       a0;
    logic [4:0]       a1;
    logic [WIDTH-1:0] wd0;
    logic [WIDTH-1:0] wd1;
    logic [1:0]       exp_ready;
  } vec_t;

  typedef struct {
    logic [1:0]       v;
    logic [WIDTH-1:0] rd;
  } rsp_t;

  vec_t             vecs [24];
  rsp_t             sb [$];
  logic [WIDTH-1:0] last_exp_rd;
  int               checks;
  int               errors;

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                              input logic [1:0] lock, input logic [4:0] a0,
                              input logic [4:0] a1, input logic [WIDTH-1:0] wd0,
                              input logic [WIDTH-1:0] wd1, input logic [1:0] exp_ready);
    vec_t v;
    v.valid = valid; v.we = we; v.lock = lock; v.a0 = a0; v.a1 = a1;
    v.wd0 = wd0; v.wd1 = wd1; v.exp_ready = exp_ready;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = v.valid;
    req_we    = v.we;
    req_lock  = v.lock;
    req_addr  = {v.a1, v.a0};
    req_wd    = {v.wd1, v.wd0};
  endtask

  // One cycle: drive, check combinational grant, predict response, check it after the edge.
  task automatic step(input int idx, input vec_t v);
    logic             g;
    logic             we;
    logic [4:0]       a;
    logic [WIDTH-1:0] wd;
    rsp_t             e;
    rsp_t             got;
    drive(v);
    #2;
    chk($sformatf("ready[%0d]", idx), 64'(req_ready), 64'(v.exp_ready));
    if (v.exp_ready != 2'b00) begin
      g  = v.exp_ready[1];
      we = v.we[g];
      a  = g ? v.a1 : v.a0;
      wd = g ? v.wd1 : v.wd0;
      chk($sformatf("mem_cs[%0d]", idx), 64'(mem_cs), 64'd1);
      chk($sformatf("mem_we[%0d]", idx), 64'(mem_we), 64'(we));
      chk($sformatf("mem_addr[%0d]", idx), 64'(mem_addr), 64'(a));
      e.v = v.exp_ready;
      if (we) begin
        e.rd = '0;
        shadow[a] = wd;
      end else begin
        e.rd = shadow[a];
      end
      last_exp_rd = e.rd;
    end else begin
      chk($sformatf("mem_cs[%0d]", idx), 64'(mem_cs), 64'd0);
      e.v  = 2'b00;
      e.rd = last_exp_rd;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk($sformatf("rsp_valid[%0d]", idx), 64'(rsp_valid), 64'(got.v));
    chk($sformatf("rsp_rd[%0d]", idx), 64'(rsp_rd), 64'(got.rd));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_exp_rd = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = init_val(i);
      shadow[i] = init_val(i);
    end

    // Round-robin after reset: requester 0 wins the first tie.
    vecs[0]  = mk(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, 2'b01);
    vecs[1]  = mk(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, 2'b10);
    vecs[2]  = mk(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, 2'b01);
    vecs[3]  = mk(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, 2'b10);
    // Single write then read back.
    vecs[4]  = mk(2'b01, 2'b01, 2'b00, 5'd3, 5'd0, 32'hDEADBEEF, '0, 2'b01);
    vecs[5]  = mk(2'b01, 2'b00, 2'b00, 5'd3, 5'd0, '0, '0, 2'b01);
    vecs[6]  = mk(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, 2'b00);
    vecs[7]  = mk(2'b10, 2'b00, 2'b00, 5'd0, 5'd7, '0, '0, 2'b10);
    // Atomic RMW on addr 5 with requester 1 waiting.
    vecs[8]  = mk(2'b11, 2'b00, 2'b01, 5'd5, 5'd5, '0, '0, 2'b01);
    vecs[9]  = mk(2'b11, 2'b01, 2'b00, 5'd5, 5'd5, 32'h12345678, '0, 2'b01);
    vecs[10] = mk(2'b10, 2'b00, 2'b00, 5'd5, 5'd5, '0, '0, 2'b10);
    // Lock timeout: 5 owner grants, then requester 1.
    vecs[11] = mk(2'b11, 2'b00, 2'b01, 5'd6, 5'd8, '0, 32'hA5A50001, 2'b01);
    vecs[12] = mk(2'b11, 2'b00, 2'b01, 5'd6, 5'd8, '0, 32'hA5A50001, 2'b01);
    vecs[13] = mk(2'b11, 2'b00, 2'b01, 5'd6, 5'd8, '0, 32'hA5A50001, 2'b01);
    vecs[14] = mk(2'b11, 2'b00, 2'b01, 5'd6, 5'd8, '0, 32'hA5A50001, 2'b01);
    vecs[15] = mk(2'b11, 2'b00, 2'b01, 5'd6, 5'd8, '0, 32'hA5A50001, 2'b01);
    vecs[16] = mk(2'b11, 2'b10, 2'b01, 5'd6, 5'd8, '0, 32'hA5A50001, 2'b10);
    // Idle owner: lock, then 4 empty cycles, then requester 1 (its lock ignored).
    vecs[17] = mk(2'b11, 2'b00, 2'b01, 5'd6, 5'd8, '0, '0, 2'b01);
    vecs[18] = mk(2'b10, 2'b00, 2'b10, 5'd6, 5'd8, '0, '0, 2'b00);
    vecs[19] = mk(2'b10, 2'b00, 2'b00, 5'd6, 5'd8, '0, '0, 2'b00);
    vecs[20] = mk(2'b10, 2'b00, 2'b00, 5'd6, 5'd8, '0, '0, 2'b00);
    vecs[21] = mk(2'b10, 2'b00, 2'b00, 5'd6, 5'd8, '0, '0, 2'b00);
    vecs[22] = mk(2'b10, 2'b00, 2'b00, 5'd6, 5'd8, '0, '0, 2'b10);
    vecs[23] = mk(2'b10, 2'b00, 2'b00, 5'd6, 5'd8, '0, '0, 2'b10);

    rst = 1'b1;
    drive(mk(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, 2'b00));
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_cs", 64'(mem_cs), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rd", 64'(rsp_rd), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) step(i, vecs[i]);

    // Reset mid-operation while locked with a response in flight.
    drive(mk(2'b01, 2'b00, 2'b01, 5'd5, 5'd8, '0, '0, 2'b00));
    #2;
    chk("midrst_grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("midrst_rsp_before", 64'(rsp_valid), 64'd1);
    drive(mk(2'b11, 2'b00, 2'b01, 5'd5, 5'd8, '0, '0, 2'b00));
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_rd", 64'(rsp_rd), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    chk("midrst_mem_cs", 64'(mem_cs), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(2'b10, 2'b00, 2'b00, 5'd5, 5'd8, '0, '0, 2'b00));
    #2;
    chk("postrst_unlocked", 64'(req_ready), 64'd2);
    @(posedge clk);
    #1;
    chk("postrst_rsp", 64'(rsp_valid), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
